sdram_mem_tester: RTL and testbench
===================================

Name: sdram_mem_tester

Overview:
- Avalon-MM master that drives the SDRAM controller's slave port inside the system.
- On `start`, it writes a deterministic pattern across a word-address range, then reads the range back with pipelined reads and compares each word.
- Reports busy/done, pass/fail, an error count and the first failing address.
- Used as board bring-up self-test for the 50 MHz SDRAM path.

Parameters:
- ADDR_W, 22, word-address width (4M x 16 SDRAM).
- DATA_W, 16, data width; the pattern is defined for 16 bits only.
- LAST_ADDR, 22'h3FFFFF, final word address tested; the range is 0..LAST_ADDR inclusive.
- SEED, 16'hA5C3, XOR seed for the pattern.
- MAX_PEND, 4, maximum outstanding reads (1..8).

Ports:
- clk  in  1  system clock (50 MHz)
- reset  in  1  asynchronous, active-high reset
- start  in  1  single-cycle pulse; starts a test when idle
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse when the test completes
- pass  out  1  valid from done; 1 if err_count==0; holds until next start
- err_count  out  16  number of mismatching words; saturates at 16'hFFFF
- first_err_addr  out  ADDR_W  address of the first mismatch; 0 if none
- avm_address  out  ADDR_W  word address
- avm_write  out  1  write request
- avm_writedata  out  DATA_W  write data
- avm_read  out  1  read request
- avm_byteenable  out  2  constant 2'b11
- avm_waitrequest  in  1  slave stall
- avm_readdata  in  DATA_W  read data
- avm_readdatavalid  in  1  read data strobe

Behaviour:
- Pattern: P(a) = a[15:0] ^ {10'b0, a[21:16]} ^ SEED.
- Reset (async, active-high), all outputs:
  - busy=0, done=0, pass=0, err_count=0, first_err_addr=0.
  - avm_read=0, avm_write=0, avm_address=0, avm_writedata=0.
  - FSM goes to IDLE; address, return and pending counters clear.
- Reset asserted mid-test aborts immediately; no further bus requests are issued.
- FSM states: IDLE, WRITE, READ, DRAIN, FINISH.
- IDLE:
  - start=1 → WRITE.
  - Clear err_count, first_err_addr, pass and the counters; busy=1 from the next cycle.
  - start while busy is ignored.
- WRITE:
  - avm_write=1, avm_address=wa, avm_writedata=P(wa).
  - Request signals hold stable while avm_waitrequest=1.
  - A write is accepted in a cycle with avm_write=1 and waitrequest=0.
  - On accept: if wa==LAST_ADDR go to READ with ra=0, else wa+1.
  - No idle cycle between back-to-back writes.
- READ:
  - avm_read=1 only when pend<MAX_PEND; otherwise avm_read=0 and the address holds.
  - On accept (read=1, waitrequest=0): ra+1.
  - On accepting the read of LAST_ADDR → DRAIN.
- pend tracking:
  - Increments on a read accept and decrements on readdatavalid.
  - Both in the same cycle: pend unchanged.
  - pend never exceeds MAX_PEND.
- Compare (READ or DRAIN):
  - On avm_readdatavalid, compare avm_readdata with P(ca), then ca+1.
  - On mismatch: err_count+1 (saturating).
  - If it is the first mismatch, first_err_addr=ca.
  - Responses are in order; ca tracks return order, not issue order.
- DRAIN: waits until pend==0 and ca==LAST_ADDR+1 → FINISH.
- FINISH (one cycle): done=1, busy=0, pass=(err_count==0), then → IDLE.
- avm_read and avm_write are never both 1.
- readdatavalid in IDLE/WRITE (spurious) is ignored.
- LAST_ADDR=0 → exactly one write and one read.
- Address counters are ADDR_W+1 bits internally so the LAST_ADDR=all-ones case terminates without wrap.
- Latency: the first write is asserted 1 cycle after start.
- Fully pipelined throughput: 1 write/cycle and 1 read/cycle with waitrequest=0 and sufficient readdatavalid.

Test Plan:
- Ideal model, LAST_ADDR=15, no waitrequest, 2-cycle read latency:
  - 16 writes on consecutive cycles with writedata(0)=16'hA5C3 and writedata(5)=16'hA5C6.
  - Then 16 reads.
  - done pulses once; pass=1, err_count=0, busy low after done.
- Model corrupts the word at address 9 (bit0 flipped), LAST_ADDR=15:
  - pass=0, err_count=1, first_err_addr=9.
  - Corrupting addresses 3 and 12 instead → err_count=2, first_err_addr=3.
- Random waitrequest (50%) in both phases:
  - Address and data hold while stalled.
  - Every address is written exactly once; pass=1.
- Read latency 10 cycles, MAX_PEND=4:
  - Never more than 4 reads are outstanding.
  - avm_read drops while pend==4; all 16 words are compared; pass=1.
- Reset asserted during the READ phase (address 7):
  - All outputs return to reset values asynchronously.
  - A subsequent start runs a full, clean test with pass=1.
- Edge cases:
  - LAST_ADDR=0 → one write (data 16'hA5C3), one read, done.
  - A start pulse while busy has no effect on counts or timing.

Source files
------------

// File: rtl/sdram_mem_tester.sv
// Avalon-MM bring-up master: writes an address-derived pattern over 0..LAST_ADDR,
// then reads it back with up to MAX_PEND reads in flight and tallies mismatches.
module sdram_mem_tester #(
  parameter int                ADDR_W    = 22,
  parameter int                DATA_W    = 16,
  parameter logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}},
  parameter logic [15:0]       SEED      = 16'hA5C3,
  parameter int                MAX_PEND  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [15:0]       err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_write,
  output logic [DATA_W-1:0] avm_writedata,
  output logic              avm_read,
  output logic [1:0]        avm_byteenable,
  input  logic              avm_waitrequest,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_readdatavalid
);
  // One extra counter bit lets an all-ones LAST_ADDR reach LAST_ADDR+1 without wrapping.
  localparam int            CW       = ADDR_W + 1;
  localparam logic [CW-1:0] LAST_C   = {1'b0, LAST_ADDR};
  localparam logic [CW-1:0] END_C    = LAST_C + CW'(1);
  localparam logic [3:0]    PEND_MAX = 4'(MAX_PEND);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WRITE  = 3'd1;
  localparam logic [2:0] S_READ   = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_FINISH = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [CW-1:0]     wa_q, wa_d;
  logic [CW-1:0]     ra_q, ra_d;
  logic [CW-1:0]     ca_q, ca_d;
  logic [3:0]        pend_q, pend_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [15:0]       err_q, err_d;
  logic [ADDR_W-1:0] ferr_q, ferr_d;

  logic wr_acc, rd_acc, rsp;

  function automatic logic [DATA_W-1:0] pattern(input logic [CW-1:0] a);
    logic [21:0] a22;
    a22 = 22'(a);
    return DATA_W'(a22[15:0] ^ {10'b0, a22[21:16]} ^ SEED);
  endfunction

  // Bus requests are pure functions of registered state, so reset clears them at once.
  assign avm_write      = (state_q == S_WRITE);
  assign avm_read       = (state_q == S_READ) && (pend_q < PEND_MAX);
  assign avm_address    = avm_write ? wa_q[ADDR_W-1:0] :
                          (state_q == S_READ) ? ra_q[ADDR_W-1:0] : '0;
  assign avm_writedata  = avm_write ? pattern(wa_q) : '0;
  assign avm_byteenable = 2'b11;

  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign first_err_addr = ferr_q;

  always_comb begin
    state_d = state_q;
    wa_d    = wa_q;
    ra_d    = ra_q;
    ca_d    = ca_q;
    pend_d  = pend_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    err_d   = err_q;
    ferr_d  = ferr_q;

    wr_acc = avm_write && !avm_waitrequest;
    rd_acc = avm_read && !avm_waitrequest;
    // Responses only count while reads can be outstanding; strays are dropped.
    rsp    = avm_readdatavalid && (pend_q != 4'd0) &&
             ((state_q == S_READ) || (state_q == S_DRAIN));

    if (rd_acc && !rsp)
      pend_d = pend_q + 4'd1;
    else if (!rd_acc && rsp)
      pend_d = pend_q - 4'd1;

    if (rsp) begin
      ca_d = ca_q + CW'(1);
      if (avm_readdata != pattern(ca_q)) begin
        if (err_q != 16'hFFFF)
          err_d = err_q + 16'd1;
        if (err_q == 16'd0)
          ferr_d = ca_q[ADDR_W-1:0];
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_WRITE;
          busy_d  = 1'b1;
          pass_d  = 1'b0;
          err_d   = 16'd0;
          ferr_d  = '0;
          wa_d    = '0;
          ra_d    = '0;
          ca_d    = '0;
          pend_d  = 4'd0;
        end
      end
      S_WRITE: begin
        if (wr_acc) begin
          if (wa_q == LAST_C) begin
            state_d = S_READ;
            ra_d    = '0;
          end else begin
            wa_d = wa_q + CW'(1);
          end
        end
      end
      S_READ: begin
        if (rd_acc) begin
          ra_d = ra_q + CW'(1);
          if (ra_q == LAST_C)
            state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if ((pend_q == 4'd0) && (ca_q == END_C)) begin
          state_d = S_FINISH;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          pass_d  = (err_q == 16'd0);
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      wa_q    <= '0;
      ra_q    <= '0;
      ca_q    <= '0;
      pend_q  <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= 16'd0;
      ferr_q  <= '0;
    end else begin
      state_q <= state_d;
      wa_q    <= wa_d;
      ra_q    <= ra_d;
      ca_q    <= ca_d;
      pend_q  <= pend_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      ferr_q  <= ferr_d;
    end
  end
endmodule

// File: tb/tb_sdram_mem_tester.sv
// Bench for sdram_mem_tester: a memory responder, a scoreboard monitor fed by
// expected-write/read/result queues, and a directed test sequence.
module tb_sdram_mem_tester;
  localparam int AW = 22;
  localparam int MP = 4;

  typedef struct { logic [21:0] addr; logic [15:0] data; } wr_t;
  typedef struct { logic pass; logic [15:0] errs; logic [21:0] first; } res_t;
  typedef struct { int due; logic [15:0] data; } rsp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, start, start0;
  logic busy, done, pass;
  logic [15:0] err_count;
  logic [AW-1:0] first_err_addr, avm_address;
  logic avm_write, avm_read, avm_waitrequest, avm_readdatavalid;
  logic [15:0] avm_writedata, avm_readdata;
  logic [1:0] avm_byteenable;

  logic z_busy, z_done, z_pass, z_write, z_read, z_wait, z_rdv;
  logic [15:0] z_err, z_writedata, z_rdata;
  logic [AW-1:0] z_ferr, z_address;
  logic [1:0] z_be;

  sdram_mem_tester #(.ADDR_W(AW), .DATA_W(16), .LAST_ADDR(22'd15), .SEED(16'hA5C3), .MAX_PEND(MP)) u_dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_err_addr(first_err_addr), .avm_address(avm_address),
    .avm_write(avm_write), .avm_writedata(avm_writedata), .avm_read(avm_read),
    .avm_byteenable(avm_byteenable), .avm_waitrequest(avm_waitrequest),
    .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid));

  sdram_mem_tester #(.ADDR_W(AW), .DATA_W(16), .LAST_ADDR(22'd0), .SEED(16'hA5C3), .MAX_PEND(MP)) u_dut0 (
    .clk(clk), .reset(reset), .start(start0), .busy(z_busy), .done(z_done), .pass(z_pass),
    .err_count(z_err), .first_err_addr(z_ferr), .avm_address(z_address),
    .avm_write(z_write), .avm_writedata(z_writedata), .avm_read(z_read),
    .avm_byteenable(z_be), .avm_waitrequest(z_wait),
    .avm_readdata(z_rdata), .avm_readdatavalid(z_rdv));

  // P(a) for a = 0..15, worked out by hand: 16'hA5C3 ^ a.
  logic [15:0] tbl [16] = '{16'hA5C3, 16'hA5C2, 16'hA5C1, 16'hA5C0, 16'hA5C7, 16'hA5C6,
                            16'hA5C5, 16'hA5C4, 16'hA5CB, 16'hA5CA, 16'hA5C9, 16'hA5C8,
                            16'hA5CF, 16'hA5CE, 16'hA5CD, 16'hA5CC};
  logic [15:0] mem [16];
  logic [15:0] cmask;
  int wr_prob, rd_lat, cyc;
  int checks, errors;
  int done_cnt, done_cyc, st_cyc, wr_cnt, rd_cnt, rdv_cnt, max_outst;
  int z_wr_cnt, z_rd_cnt, z_done_cnt, z_cd;
  logic [21:0] z_waddr, z_raddr;
  logic [15:0] z_wdata, z_mem, z_err_s;
  logic z_pass_s, z_be_ok;

  wr_t exp_wr[$];
  logic [21:0] exp_rd[$];
  res_t exp_res[$];
  rsp_t rsp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Responder for the main DUT: memory, optional stalls, fixed-latency in-order reads.
  initial begin
    avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0; avm_readdata = 16'h0; cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      avm_readdatavalid = 1'b0;
      if (reset) begin
        rsp_q.delete();
        avm_waitrequest = 1'b0;
      end else begin
        if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
          avm_readdatavalid = 1'b1;
          avm_readdata = rsp_q[0].data;
          void'(rsp_q.pop_front());
        end
        avm_waitrequest = (wr_prob > 0) ? (int'($urandom_range(0, 99)) < wr_prob) : 1'b0;
        if (avm_write && !avm_waitrequest) mem[avm_address[3:0]] = avm_writedata;
        if (avm_read && !avm_waitrequest) begin
          rsp_t r;
          r.due = cyc + rd_lat;
          r.data = mem[avm_address[3:0]] ^ {15'b0, cmask[avm_address[3:0]]};
          rsp_q.push_back(r);
        end
      end
    end
  end

  // Scoreboard monitor: pops expectations as the DUT presents transactions.
  initial begin
    int outst;
    bit stall_w, stall_r;
    logic [21:0] h_addr;
    logic [15:0] h_data;
    wr_t w;
    res_t r;
    logic [21:0] ea;
    outst = 0; stall_w = 0; stall_r = 0; h_addr = '0; h_data = '0;
    forever begin
      @(negedge clk); #1;
      if (reset) begin
        outst = 0; stall_w = 0; stall_r = 0;
        continue;
      end
      if (avm_read || avm_write) check("rw_exclusive", 32'(avm_read & avm_write), 32'd0);
      if (stall_w) begin
        check("wr_hold_req", 32'(avm_write), 32'd1);
        check("wr_hold_addr", 32'(avm_address), 32'(h_addr));
        check("wr_hold_data", 32'(avm_writedata), 32'(h_data));
      end
      if (stall_r) begin
        check("rd_hold_req", 32'(avm_read), 32'd1);
        check("rd_hold_addr", 32'(avm_address), 32'(h_addr));
      end
      if (outst >= MP) check("rd_blocked_at_max_pend", 32'(avm_read), 32'd0);
      if (outst > max_outst) max_outst = outst;
      if (avm_readdatavalid) begin rdv_cnt++; outst--; end
      if (avm_write && !avm_waitrequest) begin
        wr_cnt++;
        $display("[%0t] WR addr=%0d data=%04h", $time, avm_address, avm_writedata);
        if (exp_wr.size() == 0) check("wr_unexpected", 32'd1, 32'd0);
        else begin
          w = exp_wr.pop_front();
          check("wr_addr", 32'(avm_address), 32'(w.addr));
          check("wr_data", 32'(avm_writedata), 32'(w.data));
          check("wr_byteenable", 32'(avm_byteenable), 32'h3);
        end
      end
      if (avm_read && !avm_waitrequest) begin
        rd_cnt++; outst++;
        $display("[%0t] RD addr=%0d", $time, avm_address);
        if (exp_rd.size() == 0) check("rd_unexpected", 32'd1, 32'd0);
        else begin
          ea = exp_rd.pop_front();
          check("rd_addr", 32'(avm_address), 32'(ea));
        end
      end
      stall_w = avm_write && avm_waitrequest;
      stall_r = avm_read && avm_waitrequest;
      h_addr = avm_address; h_data = avm_writedata;
      if (done) begin
        done_cnt++; done_cyc = cyc;
        $display("[%0t] DONE pass=%0b err_count=%0d first_err_addr=%0d", $time, pass, err_count, first_err_addr);
        if (exp_res.size() == 0) check("done_unexpected", 32'd1, 32'd0);
        else begin
          r = exp_res.pop_front();
          check("pass", 32'(pass), 32'(r.pass));
          check("err_count", 32'(err_count), 32'(r.errs));
          check("first_err_addr", 32'(first_err_addr), 32'(r.first));
          check("busy_at_done", 32'(busy), 32'd0);
        end
      end
    end
  end

  // Responder for the single-word instance: no stalls, 2-cycle read latency.
  initial begin
    z_wait = 1'b0; z_rdv = 1'b0; z_rdata = 16'h0; z_cd = 0; z_mem = 16'hFFFF;
    forever begin
      @(negedge clk);
      z_rdv = 1'b0;
      if (reset) z_cd = 0;
      else begin
        if (z_cd > 0) begin
          z_cd--;
          if (z_cd == 0) begin z_rdv = 1'b1; z_rdata = z_mem; end
        end
        if (z_write) begin
          z_wr_cnt++; z_waddr = z_address; z_wdata = z_writedata; z_mem = z_writedata;
          z_be_ok = (z_be == 2'b11);
        end
        if (z_read) begin z_rd_cnt++; z_raddr = z_address; z_cd = 2; end
        if (z_done) begin z_done_cnt++; z_pass_s = z_pass; z_err_s = z_err; end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_pass"}, 32'(pass), 32'd0);
    check({tag, "_err_count"}, 32'(err_count), 32'd0);
    check({tag, "_first_err_addr"}, 32'(first_err_addr), 32'd0);
    check({tag, "_avm_read"}, 32'(avm_read), 32'd0);
    check({tag, "_avm_write"}, 32'(avm_write), 32'd0);
    check({tag, "_avm_address"}, 32'(avm_address), 32'd0);
    check({tag, "_avm_writedata"}, 32'(avm_writedata), 32'd0);
  endtask

  task automatic arm(input int wp, input int lat, input logic [15:0] cm,
                     input logic ep, input int ee, input int ef);
    wr_t w;
    res_t r;
    wr_prob = wp; rd_lat = lat; cmask = cm;
    for (int a = 0; a < 16; a++) begin
      mem[a] = 16'hFFFF;
      w.addr = 22'(a); w.data = tbl[a];
      exp_wr.push_back(w);
      exp_rd.push_back(22'(a));
    end
    r.pass = ep; r.errs = 16'(ee); r.first = 22'(ef);
    exp_res.push_back(r);
    done_cnt = 0; wr_cnt = 0; rd_cnt = 0; rdv_cnt = 0; max_outst = 0;
    @(negedge clk); #2; start = 1'b1; st_cyc = cyc;
    @(negedge clk); #2; start = 1'b0;
  endtask

  task automatic run_test(input string name, input int wp, input int lat, input logic [15:0] cm,
                          input logic ep, input int ee, input int ef, input int exp_lat, input int exp_max);
    $display("[%0t] TEST %s", $time, name);
    arm(wp, lat, cm, ep, ee, ef);
    repeat (3) @(negedge clk);
    #2; start = 1'b1;                      // ignored: DUT is busy writing
    @(negedge clk); #2; start = 1'b0;
    for (int i = 0; i < 3000 && done_cnt == 0; i++) @(negedge clk);
    #2;
    if (done_cnt == 0) begin
      check({name, "_done_timeout"}, 32'd0, 32'd1);
      reset = 1'b1;
      exp_wr.delete(); exp_rd.delete(); exp_res.delete();
      @(negedge clk); @(negedge clk); #3; reset = 1'b0;
    end else begin
      if (exp_lat > 0) check({name, "_done_latency"}, 32'(done_cyc - st_cyc), 32'(exp_lat));
      if (exp_max > 0) check({name, "_max_outstanding"}, 32'(max_outst), 32'(exp_max));
      repeat (3) @(negedge clk);
      #2;
      check({name, "_done_pulses"}, 32'(done_cnt), 32'd1);
      check({name, "_busy_after"}, 32'(busy), 32'd0);
      check({name, "_pass_held"}, 32'(pass), 32'(ep));
      check({name, "_err_held"}, 32'(err_count), 32'(ee));
      check({name, "_writes"}, 32'(wr_cnt), 32'd16);
      check({name, "_reads"}, 32'(rd_cnt), 32'd16);
      check({name, "_responses"}, 32'(rdv_cnt), 32'd16);
      check({name, "_wr_left"}, 32'(exp_wr.size()), 32'd0);
      check({name, "_rd_left"}, 32'(exp_rd.size()), 32'd0);
    end
  endtask

  initial begin
    checks = 0; errors = 0; reset = 1'b1; start = 1'b0; start0 = 1'b0;
    wr_prob = 0; rd_lat = 2; cmask = 16'h0;
    z_wr_cnt = 0; z_rd_cnt = 0; z_done_cnt = 0;
    z_waddr = '1; z_raddr = '1; z_wdata = 16'h0; z_err_s = 16'hFFFF; z_pass_s = 1'b0; z_be_ok = 1'b0;
    #3;
    check_reset_outputs("por");
    @(negedge clk); @(negedge clk); #3; reset = 1'b0;

    run_test("ideal", 0, 2, 16'h0000, 1'b1, 0, 0, 36, 0);
    run_test("corrupt9", 0, 2, 16'h0200, 1'b0, 1, 9, 36, 0);
    run_test("corrupt3_12", 0, 2, 16'h1008, 1'b0, 2, 3, 0, 0);
    run_test("random_wait", 50, 2, 16'h0000, 1'b1, 0, 0, 0, 0);
    run_test("latency10", 0, 10, 16'h0000, 1'b1, 0, 0, 0, MP);

    $display("[%0t] TEST reset_mid_read", $time);
    arm(0, 3, 16'h0000, 1'b1, 0, 0);
    for (int i = 0; i < 500 && !(avm_read && avm_address == 22'd7); i++) @(negedge clk);
    #3;
    check("reached_read7", 32'(avm_read && avm_address == 22'd7), 32'd1);
    reset = 1'b1;
    #1;
    check_reset_outputs("midreset");
    exp_wr.delete(); exp_rd.delete(); exp_res.delete();
    @(negedge clk); @(negedge clk); #3; reset = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    check("post_reset_no_write", 32'(avm_write), 32'd0);
    check("post_reset_no_read", 32'(avm_read), 32'd0);
    check("post_reset_idle", 32'(busy), 32'd0);
    run_test("after_reset", 0, 2, 16'h0000, 1'b1, 0, 0, 36, 0);

    $display("[%0t] TEST last_addr_0", $time);
    @(negedge clk); #2; start0 = 1'b1;
    @(negedge clk); #2; start0 = 1'b0;
    for (int i = 0; i < 200 && z_done_cnt == 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    #2;
    check("la0_done_pulses", 32'(z_done_cnt), 32'd1);
    check("la0_writes", 32'(z_wr_cnt), 32'd1);
    check("la0_write_addr", 32'(z_waddr), 32'd0);
    check("la0_write_data", 32'(z_wdata), 32'hA5C3);
    check("la0_byteenable", 32'(z_be_ok), 32'd1);
    check("la0_reads", 32'(z_rd_cnt), 32'd1);
    check("la0_read_addr", 32'(z_raddr), 32'd0);
    check("la0_pass", 32'(z_pass_s), 32'd1);
    check("la0_err_count", 32'(z_err_s), 32'd0);
    check("la0_first_err", 32'(z_ferr), 32'd0);
    check("la0_busy_after", 32'(z_busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end
endmodule
